// File: rtl/tdm_demux_4ch.sv
// Four-slot TDM demultiplexer: frame_sync marks slot 0, and each valid word lands in its channel register.
// Outputs are registered one cycle after the word; there is no stall, so a word is accepted on every valid cycle.
module tdm_demux_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state;
  logic [1:0] slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      ch0        <= '0;
      ch1        <= '0;
      ch2        <= '0;
      ch3        <= '0;
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              ch0      <= din;
              ch_valid <= 4'b0001;
              slot     <= 2'd1;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync on slot 0 is expected; on any other slot it is an early resync.
              sync_err <= (slot != 2'd0);
              ch0      <= din;
              ch_valid <= 4'b0001;
              slot     <= 2'd1;
            end else if (slot == 2'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end else begin
              case (slot)
                2'd1:    ch1 <= din;
                2'd2:    ch2 <= din;
                default: ch3 <= din;
              endcase
              ch_valid   <= 4'b0001 << slot;
              frame_done <= (slot == 2'd3);
              slot       <= slot + 2'd1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: a reference model predicts each cycle's outputs, and those predictions are queued and compared after the edge.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic       frame_done, locked, sync_err;

  tdm_demux_4ch #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch_valid(ch_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c0, c1, c2, c3;
    logic [3:0] cv;
    logic       fd, lk, se;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model state
  logic [7:0] m_ch[4];
  logic [1:0] m_slot;
  logic       m_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its result, then compare the prediction against the DUT after the edge.
  task automatic step(input logic r, input logic v, input logic fs, input logic [7:0] d);
    exp_t e;
    rst = r; din_valid = v; frame_sync = fs; din = d;
    e = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
      m_slot = 2'd0; m_locked = 1'b0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_ch[0] = d; e.cv = 4'b0001; m_slot = 2'd1; m_locked = 1'b1;
        end
      end else if (fs) begin
        e.se = (m_slot != 2'd0);
        m_ch[0] = d; e.cv = 4'b0001; m_slot = 2'd1;
      end else if (m_slot == 2'd0) begin
        e.se = 1'b1; m_locked = 1'b0;
      end else begin
        m_ch[m_slot] = d;
        e.cv = 4'(1 << m_slot);
        e.fd = (m_slot == 2'd3);
        m_slot = m_slot + 2'd1;
      end
    end
    e.c0 = m_ch[0]; e.c1 = m_ch[1]; e.c2 = m_ch[2]; e.c3 = m_ch[3]; e.lk = m_locked;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("ch0", 32'(ch0), 32'(e.c0));
      check("ch1", 32'(ch1), 32'(e.c1));
      check("ch2", 32'(ch2), 32'(e.c2));
      check("ch3", 32'(ch3), 32'(e.c3));
      check("ch_valid", 32'(ch_valid), 32'(e.cv));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("locked", 32'(locked), 32'(e.lk));
      check("sync_err", 32'(sync_err), 32'(e.se));
    end
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; din_valid = 1'b0; frame_sync = 1'b0;
    for (int i = 0; i < 4; i++) m_ch[i] = 8'hxx;
    m_slot = 2'd0; m_locked = 1'b0;

    // Reset takes priority over a valid sync word presented in the same cycle.
    step(1, 1, 1, 8'hEE);
    check("rst_ch0", 32'(ch0), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_cv", 32'(ch_valid), 32'h0);

    // Clean frame
    step(0, 1, 1, 8'hA1);
    check("clean_lock", 32'(locked), 32'h1);
    check("clean_cv0", 32'(ch_valid), 32'h1);
    step(0, 1, 0, 8'hB2);
    step(0, 1, 0, 8'hC3);
    step(0, 1, 0, 8'hD4);
    check("clean_fd", 32'(frame_done), 32'h1);
    check("clean_cv3", 32'(ch_valid), 32'h8);
    check("clean_chs", {ch0, ch1, ch2, ch3}, 32'hA1B2C3D4);
    step(0, 0, 0, 8'h00);
    check("idle_fd", 32'(frame_done), 32'h0);

    // Hunting: words without sync are dropped until sync arrives.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    check("hunt_drop", 32'(ch0), 32'h0);
    check("hunt_noerr", 32'(sync_err), 32'h0);
    step(0, 1, 1, 8'h33);
    check("hunt_ch0", 32'(ch0), 32'h33);
    check("hunt_lock", 32'(locked), 32'h1);

    // Early sync at slot 2
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h02);
    step(0, 1, 1, 8'h0A);
    check("early_err", 32'(sync_err), 32'h1);
    check("early_ch0", 32'(ch0), 32'h0A);
    check("early_cv", 32'(ch_valid), 32'h1);
    step(0, 1, 0, 8'h0B);
    check("early_next", 32'(ch1), 32'h0B);

    // Missing sync after a full frame
    step(0, 1, 1, 8'hE0);
    step(0, 1, 0, 8'hE1);
    step(0, 1, 0, 8'hE2);
    step(0, 1, 0, 8'hE3);
    step(0, 1, 0, 8'h55);
    check("miss_err", 32'(sync_err), 32'h1);
    check("miss_unlock", 32'(locked), 32'h0);
    check("miss_drop", 32'(ch0), 32'hE0);

    // Frame with idle gaps between words
    step(0, 1, 1, 8'h10);
    step(0, 0, 1, 8'hFF);
    step(0, 1, 0, 8'h20);
    step(0, 0, 0, 8'hFF);
    step(0, 0, 0, 8'hFF);
    step(0, 1, 0, 8'h30);
    step(0, 0, 0, 8'hFF);
    step(0, 1, 0, 8'h40);
    check("gap_chs", {ch0, ch1, ch2, ch3}, 32'h10203040);

    // Mid-frame reset
    step(0, 1, 1, 8'h71);
    step(0, 1, 0, 8'h72);
    step(1, 0, 0, 8'h00);
    check("mrst_chs", {ch0, ch1, ch2, ch3}, 32'h0);
    check("mrst_locked", 32'(locked), 32'h0);
    step(0, 1, 0, 8'h73);
    check("mrst_drop", {ch0, ch1, ch2, ch3}, 32'h0);

    // Random back-to-back traffic
    for (int i = 0; i < 200; i++)
      step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
